// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-bit framed serial link: receiver FSM states,
// line-level bit constants and the even-parity helper also used by the transmitter.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    localparam int unsigned MAX_DATA_W = 32;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Word-level valid/ready handshake between the frame receiver and its consumer.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, even parity, stop bit;
// good words go to a one-entry valid/ready holding register, errors are counted.
module serial_frame_rx
    import serial_link_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_srst,
    input  logic                 i_bit,
    input  logic                 i_bitValid,
    serial_frame_rx_if.master    rx,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_parityErrCnt,
    output logic [CNT_W-1:0]     o_frameErrCnt,
    output logic [CNT_W-1:0]     o_overflowCnt
);

    localparam int unsigned BIT_CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;

    logic                  pop;
    logic                  parity_inc;
    logic                  frame_inc;
    logic                  ovf_inc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        parity_inc = 1'b0;
        frame_inc  = 1'b0;
        ovf_inc    = 1'b0;

        pop = valid_q & rx.i_ready;
        if (pop) begin
            valid_d = 1'b0;
        end

        if (i_bitValid) begin
            unique case (state_q)
                IDLE: begin
                    if (i_bit == START_BIT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = {i_bit, shreg_q[DATA_W-1:1]};
                    cnt_d   = cnt_q + BIT_CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    perr_d  = even_parity(MAX_DATA_W'(shreg_q)) ^ i_bit;
                    state_d = STOP;
                end
                STOP: begin
                    // A bad stop bit masks parity; a good word loads only into a free
                    // or simultaneously-drained holding register.
                    state_d = IDLE;
                    if (i_bit != STOP_BIT) begin
                        frame_inc = 1'b1;
                    end else if (perr_q) begin
                        parity_inc = 1'b1;
                    end else if (!valid_q || pop) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ovf_inc = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign rx.o_data  = data_q;
    assign rx.o_valid = valid_q;
    assign o_busy     = busy_q;

    sat_counter #(.CNT_W(CNT_W)) u_parity_cnt (
        .i_clk  (i_clk),
        .i_srst (i_srst),
        .i_inc  (parity_inc),
        .o_cnt  (o_parityErrCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .i_clk  (i_clk),
        .i_srst (i_srst),
        .i_inc  (frame_inc),
        .o_cnt  (o_frameErrCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_overflow_cnt (
        .i_clk  (i_clk),
        .i_srst (i_srst),
        .i_inc  (ovf_inc),
        .o_cnt  (o_overflowCnt)
    );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed frames push expected words, a negedge
// monitor pops them on each handshake; a second instance with 2-bit counters checks saturation.
module tb_serial_frame_rx;
    import serial_link_pkg::*;

    logic clk;
    logic srst;
    logic i_bit;
    logic i_bit_valid;

    logic       busy8, busy2;
    logic [7:0] pe8, fe8, ov8;
    logic [1:0] pe2, fe2, ov2;

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    serial_frame_rx_if #(.DATA_W(8)) bus8 ();
    serial_frame_rx_if #(.DATA_W(8)) bus2 ();

    serial_frame_rx #(.DATA_W(8), .CNT_W(8)) dut8 (
        .i_clk          (clk),
        .i_srst         (srst),
        .i_bit          (i_bit),
        .i_bitValid     (i_bit_valid),
        .rx             (bus8),
        .o_busy         (busy8),
        .o_parityErrCnt (pe8),
        .o_frameErrCnt  (fe8),
        .o_overflowCnt  (ov8)
    );

    serial_frame_rx #(.DATA_W(8), .CNT_W(2)) dut2 (
        .i_clk          (clk),
        .i_srst         (srst),
        .i_bit          (i_bit),
        .i_bitValid     (i_bit_valid),
        .rx             (bus2),
        .o_busy         (busy2),
        .o_parityErrCnt (pe2),
        .o_frameErrCnt  (fe2),
        .o_overflowCnt  (ov2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus8.o_valid === 1'b1 && bus8.i_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", bus8.o_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus8.o_data !== e) begin
                    errors++;
                    $display("FAIL word_data: got %0h expected %0h", bus8.o_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int unsigned gap);
        i_bit       = b;
        i_bit_valid = 1'b1;
        tick();
        i_bit_valid = 1'b0;
        i_bit       = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int unsigned gap, input logic ready_at_stop);
        logic par;
        par = (^d) ^ bad_par;
        send_bit(1'b0, gap);
        check("busy_after_idle_bit", busy8, 0);
        send_bit(START_BIT, gap);
        for (int i = 0; i < 8; i++) begin
            check("busy_in_frame", busy8, 1);
            send_bit(d[i], gap);
        end
        check("busy_in_frame", busy8, 1);
        send_bit(par, gap);
        check("busy_at_stop", busy8, 1);
        i_bit       = stop;
        i_bit_valid = 1'b1;
        if (ready_at_stop) bus8.i_ready = 1'b1;
        tick();
        i_bit_valid = 1'b0;
        i_bit       = 1'b0;
        if (ready_at_stop) bus8.i_ready = 1'b0;
        check("busy_after_stop", busy8, 0);
    endtask

    task automatic drain_one();
        bus8.i_ready = 1'b1;
        tick();
        bus8.i_ready = 1'b0;
        check("valid_after_drain", bus8.o_valid, 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        srst         = 1'b0;
        i_bit        = 1'b0;
        i_bit_valid  = 1'b0;
        bus8.i_ready = 1'b0;
        bus2.i_ready = 1'b0;
        tick();
        do_reset();

        check("rst_valid", bus8.o_valid, 0);
        check("rst_data", bus8.o_data, 0);
        check("rst_busy", busy8, 0);
        check("rst_perr", pe8, 0);
        check("rst_ferr", fe8, 0);
        check("rst_ovf", ov8, 0);

        // Reset mid-frame: start + three data bits, then reset.
        send_bit(START_BIT, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("busy_mid_frame", busy8, 1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("busy_after_midrst", busy8, 0);
        check("valid_after_midrst", bus8.o_valid, 0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, STOP_BIT, 0, 1'b0);
        check("a5_valid", bus8.o_valid, 1);
        check("a5_data", bus8.o_data, 8'hA5);
        check("a5_perr", pe8, 0);
        check("a5_ferr", fe8, 0);
        check("a5_ovf", ov8, 0);
        drain_one();

        // Gapped bits: one valid bit every third cycle.
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, STOP_BIT, 2, 1'b0);
        check("3c_valid", bus8.o_valid, 1);
        check("3c_data", bus8.o_data, 8'h3C);
        drain_one();

        // Parity error, then frame error on a good-parity frame.
        send_frame(8'h01, 1'b1, STOP_BIT, 0, 1'b0);
        check("perr_valid", bus8.o_valid, 0);
        check("perr_cnt", pe8, 1);
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0);
        check("ferr_valid", bus8.o_valid, 0);
        check("ferr_cnt", fe8, 1);
        check("ferr_perr_unchanged", pe8, 1);

        // Backpressure: second word dropped, first word held.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, STOP_BIT, 0, 1'b0);
        send_frame(8'h22, 1'b0, STOP_BIT, 0, 1'b0);
        check("bp_data", bus8.o_data, 8'h11);
        check("bp_valid", bus8.o_valid, 1);
        check("bp_ovf", ov8, 1);
        repeat (3) tick();
        check("bp_data_hold", bus8.o_data, 8'h11);
        drain_one();
        tick();
        check("bp_valid_stays_low", bus8.o_valid, 0);

        // Simultaneous pop and load in the stop-bit cycle.
        do_reset();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, STOP_BIT, 0, 1'b0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b0, STOP_BIT, 0, 1'b1);
        check("pl_valid", bus8.o_valid, 1);
        check("pl_data", bus8.o_data, 8'h22);
        check("pl_ovf", ov8, 0);
        drain_one();

        // Saturation with 2-bit counters.
        do_reset();
        check("sat_rst", pe2, 0);
        for (int n = 0; n < 5; n++) begin
            send_frame(8'h01, 1'b1, STOP_BIT, 0, 1'b0);
        end
        check("sat_pe2", pe2, 3);
        check("sat_pe8", pe8, 5);
        send_frame(8'h5A, 1'b1, STOP_BIT, 0, 1'b0);
        repeat (2) tick();
        check("sat_pe2_hold", pe2, 3);
        check("sat_pe8_next", pe8, 6);
        check("sat_fe2", fe2, 0);

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
